// File: rtl/cache_pkg.sv
// Shared encodings and helpers for the set-associative cache controller.
package cache_pkg;

  localparam int unsigned KeyMax = 256;
  localparam int unsigned TtlMax = 64;

  localparam logic [1:0] OpGet = 2'b00;
  localparam logic [1:0] OpPut = 2'b01;
  localparam logic [1:0] OpDel = 2'b10;
  localparam logic [1:0] OpRsv = 2'b11;

  localparam logic [1:0] StatMiss    = 2'b00;
  localparam logic [1:0] StatHit     = 2'b01;
  localparam logic [1:0] StatStored  = 2'b10;
  localparam logic [1:0] StatEvicted = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StProbe,
    StRespond
  } state_e;

  // XOR-fold: key bit i lands on set bit (i mod set_bits).
  function automatic logic [15:0] hash_set(input logic [KeyMax-1:0] key,
                                           input int unsigned key_width,
                                           input int unsigned set_bits);
    logic [15:0] h;
    h = '0;
    if (set_bits != 0) begin
      for (int unsigned i = 0; i < KeyMax; i++) begin
        if (i < key_width) h[i % set_bits] = h[i % set_bits] ^ key[i];
      end
    end
    return h;
  endfunction

  // Absolute expiry time; a zero lifetime stays zero (never expires).
  function automatic logic [TtlMax-1:0] ttl_abs(input logic [TtlMax-1:0] now,
                                                input logic [TtlMax-1:0] ttl,
                                                input int unsigned width);
    logic [TtlMax:0] sum;
    logic [TtlMax:0] lim;
    if (ttl == '0) return '0;
    sum = {1'b0, now} + {1'b0, ttl};
    if (width >= TtlMax) lim = {1'b0, {TtlMax{1'b1}}};
    else lim = ((TtlMax + 1)'(1) << width) - (TtlMax + 1)'(1);
    return (sum > lim) ? lim[TtlMax-1:0] : sum[TtlMax-1:0];
  endfunction

endpackage

// File: rtl/cache_rr_victim.sv
// Per-set round-robin victim pointers, advanced once per eviction.
module cache_rr_victim #(
  parameter int unsigned SETS = 4,
  parameter int unsigned WAYS = 4,
  localparam int unsigned SetW = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int unsigned PtrW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SetW-1:0] i_set,
  input  logic            i_advance,
  output logic [PtrW-1:0] o_ptr
);

  logic [PtrW-1:0] r_ptr [SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SETS); i++) r_ptr[i] <= '0;
    end else if (i_advance) begin
      r_ptr[i_set] <= (WAYS == 1) ? '0 : r_ptr[i_set] + PtrW'(1);
    end
  end

  assign o_ptr = r_ptr[i_set];

endmodule

// File: rtl/cache_set_assoc_controller.sv
// Set-associative cache command controller: sequential way probe, TTL expiry,
// round-robin eviction, one registered response per command.
module cache_set_assoc_controller
  import cache_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned WAYS        = 4,
  parameter int unsigned KEY_WIDTH   = 64,
  parameter int unsigned VALUE_WIDTH = 64,
  parameter int unsigned TTL_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH  = $clog2(NUM_ENTRIES),
  localparam int unsigned SETS       = NUM_ENTRIES / WAYS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TTL_WIDTH-1:0]   now_time,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [KEY_WIDTH-1:0]   cmd_key,
  input  logic [VALUE_WIDTH-1:0] cmd_value,
  input  logic [TTL_WIDTH-1:0]   cmd_ttl,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [1:0]             resp_status,
  output logic [VALUE_WIDTH-1:0] resp_value,
  output logic [TTL_WIDTH-1:0]   resp_ttl,
  output logic [ADDR_WIDTH-1:0]  mem_read_addr,
  input  logic [KEY_WIDTH-1:0]   mem_key_out,
  input  logic [VALUE_WIDTH-1:0] mem_value_out,
  input  logic [TTL_WIDTH-1:0]   mem_ttl_out,
  input  logic                   mem_valid_out,
  output logic                   mem_write_en,
  output logic [ADDR_WIDTH-1:0]  mem_write_addr,
  output logic [KEY_WIDTH-1:0]   mem_key_in,
  output logic [VALUE_WIDTH-1:0] mem_value_in,
  output logic [TTL_WIDTH-1:0]   mem_ttl_in,
  output logic                   mem_valid_in
);

  localparam int unsigned SetBits = (SETS > 1) ? $clog2(SETS) : 0;
  localparam int unsigned SetW    = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int unsigned WayW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e                 r_state;
  logic [1:0]             r_op;
  logic [KEY_WIDTH-1:0]   r_key;
  logic [VALUE_WIDTH-1:0] r_value;
  logic [TTL_WIDTH-1:0]   r_ttl;
  logic [SetW-1:0]        r_set;
  logic [WayW-1:0]        r_way;
  logic                   r_free_vld;
  logic [WayW-1:0]        r_free_way;
  logic [ADDR_WIDTH-1:0]  r_base;

  logic                   r_cmd_ready;
  logic                   r_resp_valid;
  logic [1:0]             r_resp_status;
  logic [VALUE_WIDTH-1:0] r_resp_value;
  logic [TTL_WIDTH-1:0]   r_resp_ttl;
  logic [ADDR_WIDTH-1:0]  r_rd_addr;
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_waddr;
  logic [KEY_WIDTH-1:0]   r_wkey;
  logic [VALUE_WIDTH-1:0] r_wvalue;
  logic [TTL_WIDTH-1:0]   r_wttl;
  logic                   r_wvalid;

  logic [SetW-1:0]        w_set;
  logic [ADDR_WIDTH-1:0]  w_base;
  logic                   w_live;
  logic                   w_hit;
  logic                   w_last;
  logic                   w_finish;
  logic                   w_free_vld;
  logic [WayW-1:0]        w_free_way;
  logic [WayW-1:0]        w_rr_ptr;
  logic [WayW-1:0]        w_put_way;
  logic [ADDR_WIDTH-1:0]  w_put_addr;
  logic [TTL_WIDTH-1:0]   w_put_ttl;
  logic                   w_rr_adv;

  assign w_set  = SetW'(hash_set(KeyMax'(cmd_key), KEY_WIDTH, SetBits));
  assign w_base = ADDR_WIDTH'(w_set) * ADDR_WIDTH'(WAYS);

  // ttl == now counts as expired
  assign w_live     = mem_valid_out && ((mem_ttl_out == '0) || (mem_ttl_out > now_time));
  assign w_hit      = w_live && (mem_key_out == r_key);
  assign w_last     = (r_way == WayW'(WAYS - 1));
  assign w_finish   = (r_op == OpRsv) || w_hit || w_last;
  assign w_free_vld = r_free_vld || !w_live;
  assign w_free_way = r_free_vld ? r_free_way : r_way;

  assign w_put_way  = w_free_vld ? w_free_way : w_rr_ptr;
  assign w_put_addr = w_hit ? r_rd_addr : (r_base + ADDR_WIDTH'(w_put_way));
  assign w_put_ttl  = TTL_WIDTH'(ttl_abs(TtlMax'(now_time), TtlMax'(r_ttl), TTL_WIDTH));

  assign w_rr_adv = (r_state == StProbe) && (r_op == OpPut) && w_finish && !w_hit && !w_free_vld;

  cache_rr_victim #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_rr_victim (
    .clk       (clk),
    .rst       (rst),
    .i_set     (r_set),
    .i_advance (w_rr_adv),
    .o_ptr     (w_rr_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_op          <= OpGet;
      r_key         <= '0;
      r_value       <= '0;
      r_ttl         <= '0;
      r_set         <= '0;
      r_way         <= '0;
      r_free_vld    <= 1'b0;
      r_free_way    <= '0;
      r_base        <= '0;
      r_cmd_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_status <= StatMiss;
      r_resp_value  <= '0;
      r_resp_ttl    <= '0;
      r_rd_addr     <= '0;
      r_we          <= 1'b0;
      r_waddr       <= '0;
      r_wkey        <= '0;
      r_wvalue      <= '0;
      r_wttl        <= '0;
      r_wvalid      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (cmd_valid && r_cmd_ready) begin
            r_op        <= cmd_op;
            r_key       <= cmd_key;
            r_value     <= cmd_value;
            r_ttl       <= cmd_ttl;
            r_set       <= w_set;
            r_base      <= w_base;
            r_rd_addr   <= w_base;
            r_way       <= '0;
            r_free_vld  <= 1'b0;
            r_free_way  <= '0;
            r_cmd_ready <= 1'b0;
            r_state     <= StProbe;
          end
        end
        StProbe: begin
          if (w_finish) begin
            r_state       <= StRespond;
            r_resp_valid  <= 1'b1;
            r_resp_status <= StatMiss;
            r_resp_value  <= '0;
            r_resp_ttl    <= '0;
            case (r_op)
              OpGet: begin
                if (w_hit) begin
                  r_resp_status <= StatHit;
                  r_resp_value  <= mem_value_out;
                  r_resp_ttl    <= (mem_ttl_out == '0) ? '0 : (mem_ttl_out - now_time);
                end
              end
              OpPut: begin
                r_we          <= 1'b1;
                r_waddr       <= w_put_addr;
                r_wkey        <= r_key;
                r_wvalue      <= r_value;
                r_wttl        <= w_put_ttl;
                r_wvalid      <= 1'b1;
                r_resp_status <= (w_hit || w_free_vld) ? StatStored : StatEvicted;
              end
              OpDel: begin
                if (w_hit) begin
                  r_we          <= 1'b1;
                  r_waddr       <= r_rd_addr;
                  r_wkey        <= '0;
                  r_wvalue      <= '0;
                  r_wttl        <= '0;
                  r_wvalid      <= 1'b0;
                  r_resp_status <= StatHit;
                end
              end
              default: ;
            endcase
          end else begin
            r_way     <= r_way + WayW'(1);
            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
            if (!r_free_vld && !w_live) begin
              r_free_vld <= 1'b1;
              r_free_way <= r_way;
            end
          end
        end
        StRespond: begin
          if (resp_ready) begin
            r_resp_valid  <= 1'b0;
            r_resp_status <= StatMiss;
            r_resp_value  <= '0;
            r_resp_ttl    <= '0;
            r_cmd_ready   <= 1'b1;
            r_state       <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_status    = r_resp_status;
  assign resp_value     = r_resp_value;
  assign resp_ttl       = r_resp_ttl;
  assign mem_read_addr  = r_rd_addr;
  assign mem_write_en   = r_we;
  assign mem_write_addr = r_waddr;
  assign mem_key_in     = r_wkey;
  assign mem_value_in   = r_wvalue;
  assign mem_ttl_in     = r_wttl;
  assign mem_valid_in   = r_wvalid;

endmodule

// File: tb/tb_cache_set_assoc_controller.sv
// Scoreboard bench: driver pushes expectations from a behavioural cache model,
// monitor pops and compares each response and its write strobe.
module tb_cache_set_assoc_controller;

  localparam int NE = 16;
  localparam int W  = 4;
  localparam int S  = NE / W;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] now_time;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_key;
  logic [63:0] cmd_value;
  logic [31:0] cmd_ttl;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_status;
  logic [63:0] resp_value;
  logic [31:0] resp_ttl;
  logic [3:0]  mem_read_addr;
  logic [63:0] mem_key_out;
  logic [63:0] mem_value_out;
  logic [31:0] mem_ttl_out;
  logic        mem_valid_out;
  logic        mem_write_en;
  logic [3:0]  mem_write_addr;
  logic [63:0] mem_key_in;
  logic [63:0] mem_value_in;
  logic [31:0] mem_ttl_in;
  logic        mem_valid_in;

  cache_set_assoc_controller dut (
    .clk            (clk),
    .rst            (rst),
    .now_time       (now_time),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_key        (cmd_key),
    .cmd_value      (cmd_value),
    .cmd_ttl        (cmd_ttl),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_status    (resp_status),
    .resp_value     (resp_value),
    .resp_ttl       (resp_ttl),
    .mem_read_addr  (mem_read_addr),
    .mem_key_out    (mem_key_out),
    .mem_value_out  (mem_value_out),
    .mem_ttl_out    (mem_ttl_out),
    .mem_valid_out  (mem_valid_out),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_key_in     (mem_key_in),
    .mem_value_in   (mem_value_in),
    .mem_ttl_in     (mem_ttl_in),
    .mem_valid_in   (mem_valid_in)
  );

  always #5 clk = ~clk;

  // Entry memory with asynchronous read
  logic [63:0] mk [NE];
  logic [63:0] mv [NE];
  logic [31:0] mt [NE];
  logic        mvl[NE];
  assign mem_key_out   = mk[mem_read_addr];
  assign mem_value_out = mv[mem_read_addr];
  assign mem_ttl_out   = mt[mem_read_addr];
  assign mem_valid_out = mvl[mem_read_addr];
  always @(posedge clk) begin
    if (mem_write_en) begin
      mk[mem_write_addr]  <= mem_key_in;
      mv[mem_write_addr]  <= mem_value_in;
      mt[mem_write_addr]  <= mem_ttl_in;
      mvl[mem_write_addr] <= mem_valid_in;
    end
  end

  typedef struct {
    logic [1:0]  st;
    logic [63:0] val;
    logic [31:0] ttl;
    bit          wr;
    int          waddr;
    logic [63:0] wkey;
    logic [63:0] wval;
    logic [31:0] wttl;
    bit          wvld;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   wr_count = 0;
  bit   rand_ready = 1'b0;
  bit   force_low  = 1'b0;

  // Reference model state
  logic [63:0] rk [NE];
  logic [63:0] rv [NE];
  logic [31:0] rt [NE];
  bit          rvl[NE];
  int          rr [S];

  // Last response, for directed spot checks
  logic [1:0]  last_st;
  logic [63:0] last_val;
  logic [31:0] last_ttl;
  bit          last_wr;
  int          last_waddr;
  logic [31:0] last_wttl;
  bit          last_wvld;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int hset(input logic [63:0] key);
    int h = 0;
    logic [63:0] k = key;
    for (int i = 0; i < 32; i++) begin
      h = h ^ int'(k & 64'h3);
      k = k >> 2;
    end
    return h;
  endfunction

  function automatic bit live(input int a);
    return rvl[a] && (rt[a] == 32'd0 || rt[a] > now_time);
  endfunction

  task automatic model_cmd(input logic [1:0] op, input logic [63:0] key, input logic [63:0] val,
                           input logic [31:0] ttl, output exp_t e);
    int base, set, hit, free, tgt;
    longint s;
    e = '{st: 2'd0, val: 64'd0, ttl: 32'd0, wr: 1'b0, waddr: 0, wkey: 64'd0, wval: 64'd0,
          wttl: 32'd0, wvld: 1'b0, lat: 1, acc: 0};
    if (op == 2'b11) return;
    set = hset(key);
    base = set * W;
    hit = -1;
    free = -1;
    for (int w = 0; w < W; w++) begin
      if (hit < 0) begin
        if (live(base + w) && rk[base + w] == key) hit = w;
        else if (free < 0 && !live(base + w)) free = w;
      end
    end
    e.lat = (hit >= 0) ? hit + 1 : W;
    if (op == 2'b00) begin
      if (hit >= 0) begin
        e.st  = 2'd1;
        e.val = rv[base + hit];
        e.ttl = (rt[base + hit] == 0) ? 32'd0 : rt[base + hit] - now_time;
      end
    end else if (op == 2'b01) begin
      if (hit >= 0) begin tgt = hit; e.st = 2'd2; end
      else if (free >= 0) begin tgt = free; e.st = 2'd2; end
      else begin tgt = rr[set]; e.st = 2'd3; rr[set] = (rr[set] + 1) % W; end
      s = longint'(now_time) + longint'(ttl);
      e.wr = 1'b1; e.waddr = base + tgt; e.wkey = key; e.wval = val; e.wvld = 1'b1;
      e.wttl = (ttl == 0) ? 32'd0 : ((s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0]);
      rk[base + tgt] = key; rv[base + tgt] = val; rt[base + tgt] = e.wttl;
      rvl[base + tgt] = 1'b1;
    end else if (hit >= 0) begin
      e.st = 2'd1; e.wr = 1'b1; e.waddr = base + hit; e.wvld = 1'b0;
      rk[base + hit] = '0; rv[base + hit] = '0; rt[base + hit] = '0; rvl[base + hit] = 1'b0;
    end
  endtask

  // Monitor: first response cycle pops and compares; held cycles must be stable
  bit          in_resp = 1'b0;
  logic [1:0]  cap_st;
  logic [63:0] cap_val;
  logic [31:0] cap_ttl;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_resp = 1'b0;
    end else begin
      if (mem_write_en) wr_count++;
      if (resp_valid && !in_resp) begin
        in_resp = 1'b1;
        cap_st = resp_status; cap_val = resp_value; cap_ttl = resp_ttl;
        last_st = resp_status; last_val = resp_value; last_ttl = resp_ttl;
        last_wr = mem_write_en; last_waddr = int'(mem_write_addr);
        last_wttl = mem_ttl_in; last_wvld = mem_valid_in;
        if (q.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("status", 64'(resp_status), 64'(e.st));
          chk("value", resp_value, e.val);
          chk("ttl", 64'(resp_ttl), 64'(e.ttl));
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("write_en", 64'(mem_write_en), 64'(e.wr));
          if (e.wr && mem_write_en) begin
            chk("write_addr", 64'(mem_write_addr), 64'(e.waddr));
            chk("write_key", mem_key_in, e.wkey);
            chk("write_value", mem_value_in, e.wval);
            chk("write_ttl", 64'(mem_ttl_in), 64'(e.wttl));
            chk("write_valid", 64'(mem_valid_in), 64'(e.wvld));
          end
        end
      end else if (resp_valid) begin
        chk("hold_status", 64'(resp_status), 64'(cap_st));
        chk("hold_value", resp_value, cap_val);
        chk("hold_ttl", 64'(resp_ttl), 64'(cap_ttl));
        chk("hold_no_write", 64'(mem_write_en), 64'd0);
        chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      end else if (mem_write_en) begin
        chk("stray_write", 64'(mem_write_en), 64'd0);
      end
      if (resp_valid && resp_ready) in_resp = 1'b0;
    end
  end

  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (force_low) resp_ready = 1'b0;
      else if (rand_ready) resp_ready = ($urandom_range(0, 2) != 0);
      else resp_ready = 1'b1;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [63:0] key, input logic [63:0] val,
                       input logic [31:0] ttl);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      return;
    end
    model_cmd(op, key, val, ttl, e);
    cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_value = val; cmd_ttl = ttl;
    @(posedge clk);
    #1;
    e.acc = cyc;
    q.push_back(e);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !cmd_ready || resp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("idle_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic run(input logic [1:0] op, input logic [63:0] key, input logic [63:0] val,
                     input logic [31:0] ttl);
    issue(op, key, val, ttl);
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles required fewer", cyc);
    $fatal(1);
  end

  initial begin
    int wc;
    for (int i = 0; i < NE; i++) begin
      mk[i] = '0; mv[i] = '0; mt[i] = '0; mvl[i] = 1'b0;
      rk[i] = '0; rv[i] = '0; rt[i] = '0; rvl[i] = 1'b0;
    end
    for (int i = 0; i < S; i++) rr[i] = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0; cmd_value = '0; cmd_ttl = '0;
    now_time = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_write_en", 64'(mem_write_en), 64'd0);
    chk("reset_read_addr", 64'(mem_read_addr), 64'd0);

    run(2'b00, 64'h5, 64'h0, 32'h0);
    chk("t1_status", 64'(last_st), 64'd0);
    chk("t1_value", last_val, 64'd0);
    chk("t1_nowrite", 64'(last_wr), 64'd0);

    now_time = 32'd100;
    run(2'b01, 64'h5, 64'hDEAD, 32'h0);
    chk("t2_put_status", 64'(last_st), 64'd2);
    chk("t2_put_addr", 64'(last_waddr), 64'd0);
    chk("t2_put_vld", 64'(last_wvld), 64'd1);
    run(2'b00, 64'h5, 64'h0, 32'h0);
    chk("t2_get_status", 64'(last_st), 64'd1);
    chk("t2_get_value", last_val, 64'hDEAD);

    run(2'b01, 64'hA, 64'hAAAA, 32'd10);
    chk("t3_put_addr", 64'(last_waddr), 64'd1);
    chk("t3_put_ttl", 64'(last_wttl), 64'd110);
    now_time = 32'd105;
    run(2'b00, 64'hA, 64'h0, 32'h0);
    chk("t3_get_ttl", 64'(last_ttl), 64'd5);
    now_time = 32'd110;
    run(2'b00, 64'hA, 64'h0, 32'h0);
    chk("t3_expired", 64'(last_st), 64'd0);
    now_time = 32'h20;
    run(2'b01, 64'hF, 64'hFFFF, 32'hFFFF_FFF0);
    chk("t3_sat_ttl", 64'(last_wttl), 64'hFFFF_FFFF);

    run(2'b01, 64'h5, 64'h1, 32'h0);
    run(2'b01, 64'hA, 64'h2, 32'h0);
    run(2'b01, 64'hF, 64'h3, 32'h0);
    run(2'b01, 64'h0, 64'h4, 32'h0);
    chk("t4_fill_addr", 64'(last_waddr), 64'd3);
    run(2'b01, 64'h50, 64'h5, 32'h0);
    chk("t4_evict1_status", 64'(last_st), 64'd3);
    chk("t4_evict1_addr", 64'(last_waddr), 64'd0);
    run(2'b01, 64'h55, 64'h6, 32'h0);
    chk("t4_evict2_status", 64'(last_st), 64'd3);
    chk("t4_evict2_addr", 64'(last_waddr), 64'd1);

    run(2'b10, 64'h55, 64'h0, 32'h0);
    chk("t5_del_status", 64'(last_st), 64'd1);
    chk("t5_del_addr", 64'(last_waddr), 64'd1);
    chk("t5_del_vld", 64'(last_wvld), 64'd0);
    run(2'b00, 64'h55, 64'h0, 32'h0);
    chk("t5_get_after_del", 64'(last_st), 64'd0);
    run(2'b10, 64'h55, 64'h0, 32'h0);
    chk("t5_del_again", 64'(last_st), 64'd0);
    chk("t5_del_again_nowrite", 64'(last_wr), 64'd0);

    force_low = 1'b1;
    wc = wr_count;
    issue(2'b01, 64'hF, 64'h1234, 32'h0);
    for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    force_low = 1'b0;
    wait_idle();
    chk("t6_single_write", 64'(wr_count - wc), 64'd1);

    // Abort a full-probe PUT miss during its second probe cycle
    wc = wr_count;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_key = 64'h5F; cmd_value = 64'h77; cmd_ttl = 32'h0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < S; i++) rr[i] = 0;
    @(negedge clk);
    chk("t6_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t6_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("t6_rst_write_en", 64'(mem_write_en), 64'd0);
    repeat (4) @(negedge clk);
    chk("t6_rst_no_write", 64'(wr_count - wc), 64'd0);
    run(2'b00, 64'h5F, 64'h0, 32'h0);
    chk("t6_rst_not_stored", 64'(last_st), 64'd0);

    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  op;
      logic [63:0] key;
      logic [31:0] ttl;
      op = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      key = 64'($urandom_range(0, 40));
      ttl = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      now_time = now_time + 32'($urandom_range(0, 5));
      run(op, key, {$urandom, $urandom}, ttl);
    end
    rand_ready = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_set_assoc_controller.md
Name: cache_set_assoc_controller

Overview:
Next-generation cache command controller between the host command/response channel and the flat entry memory block. Keys map to a set of WAYS consecutive entries via XOR-fold hash, and the ways are probed sequentially. Supports GET/PUT/DEL, absolute TTL expiry against a free-running time input, and per-set round-robin eviction. Replaces the direct-mapped single-probe controller.

Parameters:
NUM_ENTRIES, 16, total entries in memory block; multiple of WAYS
WAYS, 4, ways per set; power of 2, ≥1
KEY_WIDTH, 64, key bits
VALUE_WIDTH, 64, value bits
TTL_WIDTH, 32, time/TTL bits
ADDR_WIDTH, $clog2(NUM_ENTRIES), memory address bits
SETS, NUM_ENTRIES/WAYS, set count (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
now_time  in  TTL_WIDTH  current time, free-running
cmd_valid  in  1  command valid
cmd_ready  out  1  controller idle, can accept
cmd_op  in  2  00 GET, 01 PUT, 10 DEL, 11 reserved
cmd_key  in  KEY_WIDTH  key
cmd_value  in  VALUE_WIDTH  PUT value
cmd_ttl  in  TTL_WIDTH  PUT lifetime; 0 = never expires
resp_valid  out  1  response valid
resp_ready  in  1  response accepted
resp_status  out  2  00 MISS, 01 HIT, 10 STORED, 11 EVICTED
resp_value  out  VALUE_WIDTH  GET hit value, else 0
resp_ttl  out  TTL_WIDTH  GET hit remaining lifetime (0 = no expiry), else 0
mem_read_addr  out  ADDR_WIDTH  probe address (registered)
mem_key_out / mem_value_out / mem_ttl_out / mem_valid_out  in  KEY/VALUE/TTL/1  entry at mem_read_addr, same cycle (asynchronous read)
mem_write_en  out  1  one-cycle write strobe
mem_write_addr  out  ADDR_WIDTH  write address
mem_key_in / mem_value_in / mem_ttl_in / mem_valid_in  out  KEY/VALUE/TTL/1  write data

Behaviour:
- Reset (sync, rst high at posedge): state IDLE, cmd_ready=1, every other output 0, all round-robin pointers 0. Asserting rst mid-operation aborts the command with no write and no response. Memory contents are untouched.
- Accept: cmd_valid && cmd_ready at a posedge. Latch op/key/value/ttl. set = hash(key); mem_read_addr = set*WAYS + 0; cmd_ready→0; state PROBE, way=0. Op 11 skips PROBE and responds MISS one cycle later, with no write.
- Live entry: mem_valid_out && (mem_ttl_out==0 || mem_ttl_out > now_time). ttl==now_time counts as expired.
- PROBE (one cycle per way):
  - Live && key match → hit; finish.
  - Otherwise, if the entry is not live and no free way is recorded yet, record this way as free.
  - way==WAYS-1 → finish; else way++ and mem_read_addr++.
- Finish: evaluated in the final PROBE cycle; outputs registered at the edge into RESPOND.
  - GET hit: HIT, value, resp_ttl = (ttl==0) ? 0 : ttl−now_time.
  - GET miss: MISS.
  - PUT hit: overwrite hit way, status STORED.
  - PUT miss with a free way: write the lowest free way, status STORED.
  - PUT miss, set full: write way rr_ptr[set], status EVICTED, then rr_ptr[set]++ mod WAYS.
  - PUT stored ttl = (cmd_ttl==0) ? 0 : min(now_time+cmd_ttl, all-ones), i.e. saturating. Write data uses mem_valid_in=1.
  - DEL hit: write hit address with mem_valid_in=0 and other data 0, status HIT. DEL miss: MISS, no write.
- Latency: resp_valid rises p cycles after the accept edge, where p = number of ways probed (1..WAYS). mem_write_en is high exactly in the first RESPOND cycle.
- RESPOND: resp_* held stable while !resp_ready. On resp_valid && resp_ready: resp_valid→0, cmd_ready→1, state IDLE. A new accept is possible no earlier than the next cycle, so throughput is ≤1 command per p+2 cycles.
- now_time is sampled in the cycle it is used; it may change during a probe.
- SETS==1: set always 0. WAYS==1 degenerates to direct-mapped with eviction.

Decomposition:
- Package cache_pkg: op codes, status codes, state encoding, function hash_set (XOR-fold of KEY_WIDTH into $clog2(SETS) bits, 0 when SETS==1), function ttl_abs (saturating add).
- Sub-module cache_rr_victim: per-set round-robin pointer array (SETS × $clog2(WAYS)). Sync reset to 0; read by set index; advance strobe.

Test Plan:
Defaults (16 entries, 4 ways, 4 sets). Keys 0x0, 0x5, 0xA, 0xF, 0x50, 0x55 all hash to set 0.
1. Reset with all valid=0, then GET 0x5 → after 4 probes resp_valid, MISS, value 0, ttl 0, no mem_write_en.
2. now=100, PUT 0x5/0xDEAD/ttl 0 → write addr 0, ttl_in 0, valid_in 1, STORED. Then GET 0x5 → HIT, 0xDEAD, resp_ttl 0, resp_valid 1 cycle after accept.
3. TTL handling:
   - now=100, PUT 0xA ttl 10 → stored ttl 110 at addr 1.
   - GET at now=105 → HIT, resp_ttl 5. GET at now=110 → MISS.
   - PUT 0xF ttl 0xFFFFFFF0 at now=0x20 → stored ttl 0xFFFFFFFF.
4. Fill set 0 with 0x5, 0xA, 0xF, 0x0 (no expiry). PUT 0x50 → EVICTED, write addr 0. PUT 0x55 → EVICTED, write addr 1 (pointer advanced).
5. DEL of a present key → write at hit addr with valid_in 0, HIT. GET same key → MISS. DEL again → MISS, no write.
6. Hold resp_ready low 5 cycles → resp_* stable, cmd_ready 0, mem_write_en pulsed once only. Separately, assert rst during probe 2 → next cycle cmd_ready 1, resp_valid 0, no write.
